// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } hz_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic id_ex_flush;
        logic pc_sel_branch;
        logic ex_mem_write;
    } hz_ctrl_t;

    // All-zero control word: the NOP / frozen pipeline setting.
    localparam hz_ctrl_t CTRL_NOP   = hz_ctrl_t'(7'b000_0000);
    localparam hz_ctrl_t CTRL_RUN   = hz_ctrl_t'(7'b110_0001);
    localparam hz_ctrl_t CTRL_STALL = hz_ctrl_t'(7'b001_0001);
    localparam hz_ctrl_t CTRL_TAKEN = hz_ctrl_t'(7'b110_1111);
    localparam hz_ctrl_t CTRL_FLUSH = hz_ctrl_t'(7'b110_1101);

    function automatic logic reg_match(input logic       use_reg,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
        return use_reg & (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_control_unit_branch_resolver.sv
// Combinational branch decision from EX/MEM flags and comparator results.
module branch_resolver
    import hazard_pkg::*;
(
    input  logic       branch,
    input  logic       u_branch,
    input  logic [2:0] funct3,
    input  logic       equal,
    input  logic       greater,
    input  logic       lesser,
    output logic       taken
);

    logic cond;

    // Condition select; unsigned variants share the comparator outputs.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:            cond = equal;
            F3_BNE:            cond = ~equal;
            F3_BLT, F3_BLTU:   cond = lesser;
            F3_BGE, F3_BGEU:   cond = greater | equal;
            default:           cond = 1'b0;
        endcase
    end

    assign taken = u_branch | (branch & cond);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stalls, branch flushes and memory-wait freeze.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES    = 1,
    parameter bit          ZERO_REG_HAZARD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        if_id_use_rs1,
    input  logic        if_id_use_rs2,
    input  logic        id_ex_read,
    input  logic [4:0]  id_ex_rd,
    input  logic        ex_mem_branch,
    input  logic        ex_mem_u_branch,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        ex_mem_equal,
    input  logic        ex_mem_greater,
    input  logic        ex_mem_lesser,
    input  logic        mem_wait,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pc_sel_branch,
    output logic        ex_mem_write
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] freeze_count
`endif
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    hz_state_t  state_r, state_s, saved_r, saved_s, eff_state_s;
    logic [2:0] cnt_r, cnt_s;
    hz_ctrl_t   ctrl_s, out_s;
    logic       taken_s, hz_s, rd_live_s;

    branch_resolver u_branch_resolver (
        .branch   (ex_mem_branch),
        .u_branch (ex_mem_u_branch),
        .funct3   (ex_mem_funct3),
        .equal    (ex_mem_equal),
        .greater  (ex_mem_greater),
        .lesser   (ex_mem_lesser),
        .taken    (taken_s)
    );

    assign rd_live_s = ZERO_REG_HAZARD ? 1'b1 : (id_ex_rd != 5'd0);
    assign hz_s = id_ex_read & rd_live_s &
                  (reg_match(if_id_use_rs1, if_id_rs1, id_ex_rd) |
                   reg_match(if_id_use_rs2, if_id_rs2, id_ex_rd));

    // Once memory is ready the frozen cycle behaves as the state it interrupted.
    assign eff_state_s = (state_r == FREEZE) ? saved_r : state_r;

    // Next-state and control decode, priority mem_wait > taken > hazard.
    always_comb begin
        ctrl_s  = CTRL_RUN;
        state_s = RUN;
        cnt_s   = cnt_r;
        saved_s = saved_r;
        if (mem_wait) begin
            ctrl_s  = CTRL_NOP;
            state_s = FREEZE;
            saved_s = eff_state_s;
        end else if (taken_s) begin
            ctrl_s = CTRL_TAKEN;
            if (MULTI_FLUSH) begin
                state_s = FLUSH;
                cnt_s   = FLUSH_RELOAD;
            end else begin
                state_s = RUN;
                cnt_s   = 3'd0;
            end
        end else if (eff_state_s == FLUSH) begin
            ctrl_s = CTRL_FLUSH;
            if (cnt_r <= 3'd1) begin
                state_s = RUN;
                cnt_s   = 3'd0;
            end else begin
                state_s = FLUSH;
                cnt_s   = cnt_r - 3'd1;
            end
        end else if (hz_s) begin
            ctrl_s  = CTRL_STALL;
            state_s = RUN;
        end else begin
            ctrl_s  = CTRL_RUN;
            state_s = RUN;
        end
    end

    // State, counter and resume-state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= RUN;
            saved_r <= RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            saved_r <= saved_s;
            cnt_r   <= cnt_s;
        end
    end

    // Reset forces the idle RUN control word.
    always_comb begin
        if (!rst) begin
            out_s = CTRL_RUN;
        end else begin
            out_s = ctrl_s;
        end
    end

    assign pc_write      = out_s.pc_write;
    assign if_id_write   = out_s.if_id_write;
    assign id_ex_bubble  = out_s.id_ex_bubble;
    assign if_id_flush   = out_s.if_id_flush;
    assign id_ex_flush   = out_s.id_ex_flush;
    assign pc_sel_branch = out_s.pc_sel_branch;
    assign ex_mem_write  = out_s.ex_mem_write;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r, flush_cnt_r, freeze_cnt_r;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r  <= 32'd0;
            flush_cnt_r  <= 32'd0;
            freeze_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r  <= stall_cnt_r  + {31'd0, out_s.id_ex_bubble};
            flush_cnt_r  <= flush_cnt_r  + {31'd0, out_s.if_id_flush | out_s.id_ex_flush};
            freeze_cnt_r <= freeze_cnt_r + {31'd0, state_r == FREEZE};
        end
    end

    assign stall_count  = stall_cnt_r;
    assign flush_count  = flush_cnt_r;
    assign freeze_count = freeze_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: table of single-cycle vectors plus multi-cycle sequences.
module tb_hazard_control_unit;
    import hazard_pkg::*;

    localparam logic [6:0] E_IDLE  = 7'b110_0001;
    localparam logic [6:0] E_STALL = 7'b001_0001;
    localparam logic [6:0] E_TAKEN = 7'b110_1111;
    localparam logic [6:0] E_FLUSH = 7'b110_1101;
    localparam logic [6:0] E_FRZ   = 7'b000_0000;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, rdld, br, ubr, eq, gt, lt, mw;
    logic [2:0] f3;
    logic pw1, iw1, bb1, f11, f21, ps1, ew1;
    logic pw3, iw3, bb3, f13, f23, ps3, ew3;
    logic [6:0] o1, o3;
    int tests = 0;
    int fails = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, fc1, zc1, sc3, fc3, zc3;
`endif

    always #5 clk = ~clk;

    hazard_control_unit #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_use_rs1(use1), .if_id_use_rs2(use2), .id_ex_read(rdld), .id_ex_rd(rd),
        .ex_mem_branch(br), .ex_mem_u_branch(ubr), .ex_mem_funct3(f3),
        .ex_mem_equal(eq), .ex_mem_greater(gt), .ex_mem_lesser(lt), .mem_wait(mw),
        .pc_write(pw1), .if_id_write(iw1), .id_ex_bubble(bb1), .if_id_flush(f11),
        .id_ex_flush(f21), .pc_sel_branch(ps1), .ex_mem_write(ew1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc1), .flush_count(fc1), .freeze_count(zc1)
`endif
    );

    hazard_control_unit #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_use_rs1(use1), .if_id_use_rs2(use2), .id_ex_read(rdld), .id_ex_rd(rd),
        .ex_mem_branch(br), .ex_mem_u_branch(ubr), .ex_mem_funct3(f3),
        .ex_mem_equal(eq), .ex_mem_greater(gt), .ex_mem_lesser(lt), .mem_wait(mw),
        .pc_write(pw3), .if_id_write(iw3), .id_ex_bubble(bb3), .if_id_flush(f13),
        .id_ex_flush(f23), .pc_sel_branch(ps3), .ex_mem_write(ew3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc3), .flush_count(fc3), .freeze_count(zc3)
`endif
    );

    assign o1 = {pw1, iw1, bb1, f11, f21, ps1, ew1};
    assign o3 = {pw3, iw3, bb3, f13, f23, ps3, ew3};

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, rdld, br, ubr;
        logic [2:0] f3;
        logic       eq, gt, lt;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input string n, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input logic u1, input logic u2,
                                input logic ld, input logic b_, input logic ub,
                                input logic [2:0] f, input logic e, input logic g,
                                input logic l, input logic [6:0] x);
        vec_t v;
        v.name = n; v.rs1 = a; v.rs2 = b; v.rd = d; v.use1 = u1; v.use2 = u2;
        v.rdld = ld; v.br = b_; v.ubr = ub; v.f3 = f; v.eq = e; v.gt = g; v.lt = l;
        v.exp = x;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; use1 = 1'b0; use2 = 1'b0; rdld = 1'b0;
        br = 1'b0; ubr = 1'b0; f3 = 3'b000; eq = 1'b0; gt = 1'b0; lt = 1'b0; mw = 1'b0;
    endtask

    task automatic set_hz();
        rdld = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
    endtask

    // Advance to the next negedge, then settle before sampling.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(); idle_in(); rst = 1'b0;
        cyc(); rst = 1'b1;
    endtask

    initial begin
        idle_in();
        rst = 1'b0;
        vecs[0]  = mk("idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE);
        vecs[1]  = mk("loaduse_rs1", 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_STALL);
        vecs[2]  = mk("after_load",  5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE);
        vecs[3]  = mk("x0_load",     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE);
        vecs[4]  = mk("loaduse_rs2", 5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_STALL);
        vecs[5]  = mk("rs2_unused",  5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE);
        vecs[6]  = mk("bne_taken",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, E_TAKEN);
        vecs[7]  = mk("bne_not",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, E_IDLE);
        vecs[8]  = mk("beq_taken",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, E_TAKEN);
        vecs[9]  = mk("blt_taken",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, E_TAKEN);
        vecs[10] = mk("bltu_not",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, E_IDLE);
        vecs[11] = mk("bgeu_eq",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, E_TAKEN);
        vecs[12] = mk("bge_not",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, E_IDLE);
        vecs[13] = mk("f3_010",      5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, E_IDLE);
        vecs[14] = mk("jal",         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, E_TAKEN);
        vecs[15] = mk("taken_vs_hz", 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, E_TAKEN);

        // Reset: idle outputs even with hazard and branch inputs active.
        cyc(); set_hz(); ubr = 1'b1; #1;
        chk("rst_out_dut1", {25'd0, o1}, {25'd0, E_IDLE});
        chk("rst_out_dut3", {25'd0, o3}, {25'd0, E_IDLE});
        cyc(); idle_in(); rst = 1'b1; #1;
        chk("post_rst_dut3", {25'd0, o3}, {25'd0, E_IDLE});
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_freeze_cnt", zc3, 32'd0);
        chk("rst_stall_cnt", sc1, 32'd0);
`endif

        // Single-cycle vectors against the FLUSH_CYCLES=1 instance.
        for (int i = 0; i < 16; i++) begin
            cyc();
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
            use1 = vecs[i].use1; use2 = vecs[i].use2; rdld = vecs[i].rdld;
            br = vecs[i].br; ubr = vecs[i].ubr; f3 = vecs[i].f3;
            eq = vecs[i].eq; gt = vecs[i].gt; lt = vecs[i].lt; mw = 1'b0;
            #1;
            chk(vecs[i].name, {25'd0, o1}, {25'd0, vecs[i].exp});
        end

        // JAL with three flush cycles; hazard in the second cycle is ignored.
        do_reset();
        ubr = 1'b1; #1;
        chk("jal3_c1", {25'd0, o3}, {25'd0, E_TAKEN});
        cyc(); idle_in(); set_hz(); #1;
        chk("jal3_c2", {25'd0, o3}, {25'd0, E_FLUSH});
        chk("hz_dut1_c2", {25'd0, o1}, {25'd0, E_STALL});
        cyc(); idle_in(); #1;
        chk("jal3_c3", {25'd0, o3}, {25'd0, E_FLUSH});
        cyc(); #1;
        chk("jal3_c4", {25'd0, o3}, {25'd0, E_IDLE});

        // Freeze for four cycles while one flush cycle remains.
        do_reset();
        ubr = 1'b1; #1;
        chk("frz_c1", {25'd0, o3}, {25'd0, E_TAKEN});
        cyc(); ubr = 1'b0; #1;
        chk("frz_c2", {25'd0, o3}, {25'd0, E_FLUSH});
        for (int k = 0; k < 4; k++) begin
            cyc(); mw = 1'b1; #1;
            chk($sformatf("frz_hold%0d", k), {25'd0, o3}, {25'd0, E_FRZ});
        end
        cyc(); mw = 1'b0; #1;
        chk("frz_resume", {25'd0, o3}, {25'd0, E_FLUSH});
        cyc(); #1;
        chk("frz_done", {25'd0, o3}, {25'd0, E_IDLE});
`ifdef HAZARD_PERF_CNT_EN
        chk("freeze_count", zc3, 32'd4);
        chk("flush_count", fc3, 32'd3);
`endif

        // New taken branch during FLUSH reloads the counter.
        do_reset();
        ubr = 1'b1; #1;
        chk("reload_c1", {25'd0, o3}, {25'd0, E_TAKEN});
        cyc(); #1;
        chk("reload_c2", {25'd0, o3}, {25'd0, E_TAKEN});
        cyc(); ubr = 1'b0; #1;
        chk("reload_c3", {25'd0, o3}, {25'd0, E_FLUSH});
        cyc(); #1;
        chk("reload_c4", {25'd0, o3}, {25'd0, E_FLUSH});
        cyc(); #1;
        chk("reload_c5", {25'd0, o3}, {25'd0, E_IDLE});

        // Branch held in EX/MEM during freeze is acted on after unfreeze.
        do_reset();
        ubr = 1'b1; mw = 1'b1; #1;
        chk("tfrz_c1", {25'd0, o1}, {25'd0, E_FRZ});
        cyc(); #1;
        chk("tfrz_c2", {25'd0, o3}, {25'd0, E_FRZ});
        cyc(); mw = 1'b0; #1;
        chk("tfrz_c3_d1", {25'd0, o1}, {25'd0, E_TAKEN});
        chk("tfrz_c3_d3", {25'd0, o3}, {25'd0, E_TAKEN});
        cyc(); ubr = 1'b0; #1;
        chk("tfrz_c4_d1", {25'd0, o1}, {25'd0, E_IDLE});
        chk("tfrz_c4_d3", {25'd0, o3}, {25'd0, E_FLUSH});

        // Reset in the middle of a flush sequence.
        do_reset();
        ubr = 1'b1; #1;
        chk("rflush_c1", {25'd0, o3}, {25'd0, E_TAKEN});
        cyc(); ubr = 1'b0; rst = 1'b0; #1;
        chk("rflush_in_rst", {25'd0, o3}, {25'd0, E_IDLE});
        cyc(); rst = 1'b1; #1;
        chk("rflush_after", {25'd0, o3}, {25'd0, E_IDLE});
`ifdef HAZARD_PERF_CNT_EN
        chk("rflush_cnt", fc3, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage core: IF, ID, EX, MEM, WB.
- Generates PC/IF-ID write enables, ID-EX bubble insertion, and IF-ID/ID-EX flushes.
- Detects load-use hazards that forwarding cannot cover, resolves conditional/unconditional branches from EX/MEM register flags, and freezes the pipeline on data-memory wait.
- Sits beside the execution stage; consumes its registered outputs and the decode-stage register fields.

Parameters:
- FLUSH_CYCLES, 1: cycles flush stays asserted after a taken branch (1..7).
- ZERO_REG_HAZARD, 0: 1 = treat x0 as a real dependency (debug only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- if_id_rs1  in  5  rs1 field of the instruction in IF/ID.
- if_id_rs2  in  5  rs2 field of the instruction in IF/ID.
- if_id_use_rs1  in  1  IF/ID instruction reads rs1.
- if_id_use_rs2  in  1  IF/ID instruction reads rs2.
- id_ex_read  in  1  ID/EX holds a load (read_from_decoder).
- id_ex_rd  in  5  ID/EX destination (rd_from_decoder).
- ex_mem_branch  in  1  EX/MEM conditional branch flag (branch_from_execution).
- ex_mem_u_branch  in  1  EX/MEM jump flag (u_branch_from_execution).
- ex_mem_funct3  in  3  EX/MEM funct3.
- ex_mem_equal  in  1  comparator equal.
- ex_mem_greater  in  1  comparator greater.
- ex_mem_lesser  in  1  comparator lesser.
- mem_wait  in  1  data memory not ready; whole pipeline must hold.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_bubble  out  1  load ID/EX with all-zero control (NOP).
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to NOP.
- pc_sel_branch  out  1  PC takes branch_addr_from_execution.
- ex_mem_write  out  1  EX/MEM and later register enable (0 during freeze).

Behaviour:
- State machine states: RUN, FLUSH, FREEZE. Register holds state, a 3-bit flush counter and a saved_state.
- Reset (rst=0 at posedge): state=RUN, counter=0. While in reset, all outputs are driven to the RUN idle values: pc_write=1, if_id_write=1, ex_mem_write=1, all others 0.
- Taken branch decode (combinational):
  - taken = ex_mem_u_branch | (ex_mem_branch & cond).
  - cond by funct3: 000 equal; 001 !equal; 100/110 lesser; 101/111 greater|equal; any other value gives 0.
- Load-use hazard (combinational): hz = id_ex_read & id_ex_rd!=0 & ((if_id_use_rs1 & rs1==id_ex_rd) | (if_id_use_rs2 & rs2==id_ex_rd)).
  - With ZERO_REG_HAZARD=1, the rd!=0 term is dropped.
- Priority within a cycle: mem_wait > taken > hz.
- RUN:
  - mem_wait: all write enables=0 and no flush; next state FREEZE, with saved_state=RUN.
  - taken: pc_sel_branch=1, if_id_flush=1, id_ex_flush=1. Next state is FLUSH with counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, otherwise RUN.
  - hz: pc_write=0, if_id_write=0, id_ex_bubble=1, i.e. exactly one bubble. The hazard clears naturally next cycle.
- FLUSH:
  - if_id_flush=1 and id_ex_flush=1, pc_sel_branch=0, pc_write=1.
  - Counter decrements each cycle; when counter==0 and the flush is applied, next state is RUN.
  - hz is ignored while in FLUSH.
  - A new taken branch reloads the counter and asserts pc_sel_branch.
- FREEZE:
  - Outputs as in RUN-with-mem_wait.
  - On mem_wait=0, return to saved_state with the counter preserved.
  - A taken condition seen while frozen is acted on in the first cycle after unfreeze; the EX/MEM contents are held, so it re-evaluates.
- Flush and bubble are never asserted while a write enable for the same register is 0 and a freeze is active.
- Reset mid-FLUSH or mid-FREEZE returns to RUN next edge and clears the counter.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_count[31:0], flush_count[31:0], freeze_count[31:0].
  - Each counter increments by 1 on every cycle where, respectively, id_ex_bubble, (if_id_flush|id_ex_flush) or state==FREEZE is asserted.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package hazard_pkg:
  - state enum hz_state_t {RUN, FLUSH, FREEZE}.
  - funct3 constants F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
  - NOP control constant.
- One sub-module: branch_resolver, combinational funct3 + flags -> taken.

Test Plan:
- Load-use: id_ex_read=1, id_ex_rd=5, if_id_rs1=5, use_rs1=1 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle with id_ex_read=0 -> normal.
- x0 load: id_ex_rd=0, rs1=0 -> no stall (ZERO_REG_HAZARD=0).
- BNE: funct3=001, equal=0, branch=1 -> pc_sel_branch=1 and both flushes for one cycle. Same inputs with equal=1 -> no action.
- FLUSH_CYCLES=3 with JAL: u_branch=1 -> flushes held 3 cycles, pc_sel_branch only in the first; hz asserted in cycle 2 is ignored.
- Freeze: mem_wait=1 for 4 cycles mid-FLUSH (counter=1) -> all enables 0 for 4 cycles, then FLUSH resumes for the remaining cycles. With HAZARD_PERF_CNT_EN, freeze_count=4.
- Reset: rst=0 during FLUSH -> next edge state RUN, pc_write=1, all flushes 0, counters 0.
